// File: rtl/instr_decode_stage.sv
// instr_decode_stage: splits a fetched instruction into register fields, immediate and controls, one-entry pipeline register, pending-write scoreboard stall
//   clk_i, rst_i                 clock, synchronous active-high reset
//   instruction_i/in_valid_i/in_ready_o  fetch-side handshake
//   out_valid_o/out_ready_i      downstream handshake for the decoded bundle
//   flush_i                      drop held and incoming instruction
//   wb_valid_i/wb_addr_i         write-back completion, clears a pending bit
//   writereg_o..illegal_o        registered decoded bundle
//   pending_o                    scoreboard contents
module instr_decode_stage #(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 3,
  parameter int DATA_W  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [INSTR_W-1:0]     instruction_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  input  logic                   flush_i,
  input  logic                   wb_valid_i,
  input  logic [REG_AW-1:0]      wb_addr_i,
  output logic [REG_AW-1:0]      writereg_o,
  output logic [REG_AW-1:0]      readreg1_o,
  output logic [REG_AW-1:0]      readreg2_o,
  output logic [DATA_W-1:0]      immediate_o,
  output logic [DATA_W-1:0]      offset_o,
  output logic [2:0]             aluop_o,
  output logic                   imm_sel_o,
  output logic                   neg_sel_o,
  output logic                   writeenable_o,
  output logic                   branch_o,
  output logic                   jump_o,
  output logic                   illegal_o,
  output logic [(1<<REG_AW)-1:0] pending_o
);
  localparam int NR = 1 << REG_AW;
  logic [7:0] op;
  logic [REG_AW-1:0] rd, rt, rs;
  logic use_rt, use_rs, rt_busy, rs_busy, hazard, accept, issue;
  logic [2:0] aluop_d, aluop_q;
  logic [5:0] ctrl_d, ctrl_q;
  logic [NR-1:0] pending_d, pending_q, set_v, clr_v;
  logic out_valid_q;
  logic [REG_AW-1:0] writereg_q, readreg1_q, readreg2_q;
  logic [DATA_W-1:0] immediate_q, offset_q;
  logic unused_bits;
  assign op = instruction_i[INSTR_W-1 -: 8];
  assign rd = instruction_i[16 +: REG_AW];
  assign rt = instruction_i[8 +: REG_AW];
  assign rs = instruction_i[0 +: REG_AW];
  assign unused_bits = ^instruction_i[15:8+REG_AW];
  always_comb begin
    use_rt  = op inside {8'd2, 8'd3, 8'd4, 8'd5, 8'd7};
    use_rs  = use_rt || op == 8'd1;
    aluop_d = (op == 8'd2 || op == 8'd3 || op == 8'd7) ? 3'b001 :
              (op == 8'd4) ? 3'b010 : (op == 8'd5) ? 3'b011 : 3'b000;
    // {imm_sel, neg_sel, writeenable, branch, jump, illegal}
    ctrl_d  = {op == 8'd0, op == 8'd3 || op == 8'd7, op <= 8'd5, op == 8'd7, op == 8'd6, op > 8'd7};
  end
  // A source is busy if its write is outstanding or the held bundle is about to write it
  assign rt_busy = pending_q[rt] || (out_valid_q && ctrl_q[3] && rt == writereg_q);
  assign rs_busy = pending_q[rs] || (out_valid_q && ctrl_q[3] && rs == writereg_q);
  assign hazard = in_valid_i && ((use_rt && rt_busy) || (use_rs && rs_busy));
  assign in_ready_o = !rst_i && (!out_valid_q || out_ready_i) && !hazard;
  assign accept = in_valid_i && in_ready_o && !flush_i;
  assign issue = out_valid_q && out_ready_i && !flush_i;
  assign set_v = (issue && ctrl_q[3]) ? NR'(1) << writereg_q : '0;
  assign clr_v = wb_valid_i ? NR'(1) << wb_addr_i : '0;
  // set applied after clear so an issue beats a same-cycle write-back to that register
  assign pending_d = (pending_q & ~clr_v) | set_v;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      pending_q   <= '0;
      writereg_q  <= '0;
      readreg1_q  <= '0;
      readreg2_q  <= '0;
      immediate_q <= '0;
      offset_q    <= '0;
      aluop_q     <= '0;
      ctrl_q      <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= accept || (out_valid_q && !out_ready_i && !flush_i);
      if (accept) begin
        writereg_q  <= rd;
        readreg1_q  <= rt;
        readreg2_q  <= rs;
        immediate_q <= instruction_i[DATA_W-1:0];
        offset_q    <= instruction_i[16 +: DATA_W];
        aluop_q     <= aluop_d;
        ctrl_q      <= ctrl_d;
      end
    end
  end
  assign out_valid_o = out_valid_q;
  assign writereg_o = writereg_q;
  assign readreg1_o = readreg1_q;
  assign readreg2_o = readreg2_q;
  assign immediate_o = immediate_q;
  assign offset_o = offset_q;
  assign aluop_o = aluop_q;
  assign {imm_sel_o, neg_sel_o, writeenable_o, branch_o, jump_o, illegal_o} = ctrl_q;
  assign pending_o = pending_q;
endmodule
